// File: rtl/lockstep_pipe_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lockstep_pipe_checker
//  Description : LANES identical WIDTH-bit, DEPTH-stage clock-enabled
//                pipelines run in lockstep from one broadcast input word.
//                The lane tails are compared on every advance. Compare mode
//                (MODE=0) forwards lane 0. Vote mode (MODE=1) forwards the
//                bitwise majority of the lanes. Disagreements drive a
//                mismatch flag, a per-lane fault mask, a sticky error flag
//                and a saturating error counter.
//  Options     : `define LOCKSTEP_FAULT_INJECT_EN adds i_inject and
//                i_inject_mask. These corrupt the word that enters the last
//                lane, so the checker can be exercised in silicon.
//  Revision    : 1.0 - initial release
// ============================================================================
module lockstep_pipe_checker #(
    parameter int WIDTH = 8,   // data word width (>=1)
    parameter int DEPTH = 4,   // stages per lane ahead of the output register (>=1)
    parameter int LANES = 3,   // redundant lanes (>=2; odd and >=3 for vote mode)
    parameter int MODE  = 0,   // 0 = compare against lane 0, 1 = bitwise majority vote
    parameter int CNT_W = 8    // error counter width
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_ce,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
`ifdef LOCKSTEP_FAULT_INJECT_EN
    input  logic             i_inject,
    input  logic [WIDTH-1:0] i_inject_mask,
`endif
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_mismatch,
    output logic [LANES-1:0] o_fault_lane,
    output logic             o_err_sticky,
    output logic [CNT_W-1:0] o_err_count
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Reset conditioning
    // i_reset_n asserts asynchronously. Its release is retimed through two
    // flops so that every register leaves reset on the same clock edge.
    // ------------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       w_rst_n;

    // Two-flop release synchroniser. Assertion bypasses it asynchronously.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign w_rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------------
    // Input word for the last lane
    // This is the only point where the lanes may differ. With injection
    // compiled out, every lane sees i_data unmodified.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_inj_word;

`ifdef LOCKSTEP_FAULT_INJECT_EN
    assign w_inj_word = i_inject ? (i_data ^ i_inject_mask) : i_data;
`else
    assign w_inj_word = i_data;
`endif

    // ------------------------------------------------------------------------
    // Valid chain
    // One bit per stage travels alongside the data. The lanes share this
    // chain, so validity can never disagree between lanes.
    // ------------------------------------------------------------------------
    logic [DEPTH-1:0] vstage_q;
    logic             w_tail_valid;

    // Shift the valid bit one stage per advance.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            vstage_q <= '0;
        end else if (i_ce) begin
            vstage_q[0] <= i_valid;
            for (int k = 1; k < DEPTH; k++) begin
                vstage_q[k] <= vstage_q[k-1];
            end
        end
    end

    assign w_tail_valid = vstage_q[DEPTH-1];

    // ------------------------------------------------------------------------
    // Redundant lanes
    // Each lane is an identical shift register with identical reset values.
    // Only the stage-0 source of the last lane is different.
    // ------------------------------------------------------------------------
    logic [LANES-1:0][WIDTH-1:0] w_tails;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DEPTH-1:0][WIDTH-1:0] stage_q;
        logic [WIDTH-1:0]            w_stage_in;

        if (l == LANES - 1) begin : g_inj_tap
            assign w_stage_in = w_inj_word;
        end else begin : g_clean_tap
            assign w_stage_in = i_data;
        end

        // Advance this lane's data shift register.
        always_ff @(posedge i_clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                stage_q <= '0;
            end else if (i_ce) begin
                stage_q[0] <= w_stage_in;
                for (int k = 1; k < DEPTH; k++) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end
        end

        assign w_tails[l] = stage_q[DEPTH-1];
    end

    // ------------------------------------------------------------------------
    // Reference word
    // The reference is the word the module forwards, and every lane is judged
    // against it. In compare mode lane 0 is trusted, so its own fault bit is
    // always 0. In vote mode any lane that loses the vote is flagged.
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] f_majority(
        input logic [LANES-1:0][WIDTH-1:0] tails
    );
        logic [WIDTH-1:0] res;
        int               ones;
        res = '0;
        for (int b = 0; b < WIDTH; b++) begin
            ones = 0;
            for (int n = 0; n < LANES; n++) begin
                if (tails[n][b]) begin
                    ones++;
                end
            end
            res[b] = (ones > (LANES / 2));
        end
        return res;
    endfunction

    logic [WIDTH-1:0] w_ref;

    if (MODE == 1) begin : g_vote
        assign w_ref = f_majority(w_tails);
    end else begin : g_compare
        assign w_ref = w_tails[0];
    end

    // ------------------------------------------------------------------------
    // Fault detection
    // ------------------------------------------------------------------------
    logic [LANES-1:0] w_fault;
    logic             w_hit;

    // Flag every lane whose tail differs from the reference word.
    always_comb begin
        w_fault = '0;
        for (int n = 0; n < LANES; n++) begin
            w_fault[n] = (w_tails[n] != w_ref);
        end
    end

    // A counted error needs an advance, a valid tail and a disagreement.
    assign w_hit = i_ce & w_tail_valid & (|w_fault);

    // ------------------------------------------------------------------------
    // Output register
    // The fault mask and the mismatch flag are qualified by the tail valid.
    // Bubbles therefore never report errors, even though their data still
    // flows to o_data.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             mismatch_q;
    logic [LANES-1:0] fault_q;

    // Capture the reference word, valid and fault status on each advance.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
            fault_q    <= '0;
        end else if (i_ce) begin
            data_q     <= w_ref;
            valid_q    <= w_tail_valid;
            mismatch_q <= w_tail_valid & (|w_fault);
            fault_q    <= w_tail_valid ? w_fault : '0;
        end
    end

    // ------------------------------------------------------------------------
    // Error tracking
    // i_clear works with or without i_ce. If a clear coincides with a counted
    // mismatch, the new mismatch takes priority: the error is not lost, and
    // the count restarts at one.
    // ------------------------------------------------------------------------
    logic             sticky_q;
    logic             sticky_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next-state logic for the sticky flag and the saturating counter.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (w_hit) begin
            sticky_d = 1'b1;
            if (i_clear) begin
                count_d = C_CNT_ONE;
            end else if (count_q != C_CNT_MAX) begin
                count_d = count_q + C_CNT_ONE;
            end
        end else if (i_clear) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
    end

    // Error state register.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_mismatch   = mismatch_q;
    assign o_fault_lane = fault_q;
    assign o_err_sticky = sticky_q;
    assign o_err_count  = count_q;

endmodule
`default_nettype wire

// File: doc/lockstep_pipe_checker.md
Name: lockstep_pipe_checker

Overview:
- LANES identical WIDTH-bit, DEPTH-stage clock-enabled pipelines run in lockstep from the same input word.
- Lane tails are compared every advance; any disagreement raises a mismatch flag, a sticky error, a saturating error counter and a per-lane fault mask.
- MODE selects the output: lane 0 pass-through (compare) or bitwise majority (vote, TMR).
- Sits at the end of redundant datapaths as the generalised successor of the single-bit dual-pipe XOR checker.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, pipeline stages per lane before the output register (>=1).
- LANES, 3, number of redundant lanes (>=2; must be odd and >=3 when MODE=1).
- MODE, 0, 0 = compare (output lane 0), 1 = vote (bitwise majority).
- CNT_W, 8, error counter width.

Ports:
- i_clk  input  1  clock, rising edge
- i_reset_n  input  1  asynchronous active-low reset
- i_ce  input  1  pipeline advance enable
- i_valid  input  1  qualifies i_data; travels with the word
- i_data  input  WIDTH  input word, broadcast to all lanes
- i_clear  input  1  synchronous clear of sticky error and counter
- o_data  output  WIDTH  registered result word
- o_valid  output  1  registered valid for o_data
- o_mismatch  output  1  registered: the current output word had a lane disagreement
- o_fault_lane  output  LANES  registered one-hot-or-more mask of disagreeing lanes
- o_err_sticky  output  1  set on any mismatch, held until i_clear
- o_err_count  output  CNT_W  saturating count of mismatching valid words

Behaviour:
- Reset (async assert, sync release) forces all outputs to 0: o_data, o_valid, o_mismatch, o_fault_lane, o_err_sticky, o_err_count. It also clears every lane stage and every valid-chain bit.
- Advance (i_ce=1):
  - Each lane: stage[0] <= i_data; stage[k] <= stage[k-1].
  - Valid chain: vstage[0] <= i_valid; vstage[k] <= vstage[k-1].
  - Output register samples the lane tails (stage[DEPTH-1]) and vstage[DEPTH-1].
- Hold (i_ce=0): all stages, valid chain and all outputs hold their values.
- Latency: a word presented with i_ce=1 appears on o_data/o_valid after DEPTH+1 advancing edges. With i_ce held high this is DEPTH+1 clocks.
- o_valid <= vstage[DEPTH-1] on each advance.
- Compare mode (MODE=0):
  - o_data <= lane0 tail.
  - fault bit k (k>=1) = (tail_k != tail_0); bit 0 is always 0.
- Vote mode (MODE=1):
  - o_data <= bitwise majority of all lane tails.
  - fault bit k = (tail_k != voted word).
- Mismatch: o_mismatch <= |fault mask, and only when the tail valid is 1. When the tail is not valid, o_mismatch and o_fault_lane are written 0 on advance.
- Error tracking, on an advance with a valid mismatching tail:
  - o_err_sticky <= 1.
  - o_err_count increments, saturating at 2^CNT_W-1 (no wrap).
- i_clear=1 clears o_err_sticky and o_err_count whether or not i_ce is high.
- i_clear in the same cycle as a counted mismatch: the mismatch wins, giving sticky=1 and count=1.
- Reset mid-stream: all in-flight words are discarded; no residual valid or error after release.
- Lanes are structurally identical and have no reset-value differences. Without injected faults, o_mismatch must never assert.

Optional Feature:
- Macro: LOCKSTEP_FAULT_INJECT_EN.
- Defined: adds input i_inject (1 bit) and input i_inject_mask (WIDTH bits). On an advance with i_inject=1, lane LANES-1 stage[0] loads i_data ^ i_inject_mask instead of i_data. All other lanes are unaffected. This exercises the checker in silicon and simulation.
- Undefined: neither port exists, and every lane loads i_data unmodified.

Test Plan:
- Reset, then i_ce=1 with i_valid=1 and i_data=0x00..0x09 (defaults, MODE=0) -> o_data 0x00..0x09 starting 5 clocks after first input; o_valid=1 from then on; o_mismatch=0 and o_err_count=0 throughout.
- i_ce toggled 1,0,1,0 while streaming 0xA5,0x5A -> outputs hold during i_ce=0; 0xA5 appears after 5 advancing edges, not 5 clocks.
- With LOCKSTEP_FAULT_INJECT_EN, MODE=0, i_data=0x3C, inject mask 0x01 -> 5 advances later: o_data=0x3C, o_mismatch=1, o_fault_lane=3'b100, sticky=1, count=1.
- Same injection with MODE=1 -> o_data=0x3C (voted), o_fault_lane=3'b100, o_mismatch=1.
- CNT_W=2 with 5 consecutive injected valid words -> count goes 1,2,3,3,3. i_clear together with a 6th mismatch -> count=1, sticky=1. Then i_clear alone -> count=0, sticky=0.
- Assert i_reset_n=0 mid-stream with 3 words in flight, release, then hold i_valid=0 -> o_valid stays 0; o_data=0, o_mismatch=0 and sticky=0 for at least DEPTH+1 advances.
